// File: rtl/stack_controller.sv
// Multicycle control FSM for the 8-bit stack-machine datapath.
// Control strobes are registered from the next state; rst forces them low immediately.
module stack_controller #(
  parameter int unsigned STATE_W = 4,
  parameter int unsigned OPC_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               pcSrc,
  output logic               IorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               IRWrite,
  output logic               MtoS,
  output logic               ldA,
  output logic               ldB,
  output logic               srcA,
  output logic               srcB,
  output logic               push,
  output logic               pop,
  output logic               tos,
  output logic [1:0]         ALUOp,
  output logic [STATE_W-1:0] state,
  output logic               instDone
);

  typedef enum logic [STATE_W-1:0] {
    StIf    = 4'd0,
    StId    = 4'd1,
    StPopA  = 4'd2,
    StPopB  = 4'd3,
    StExec  = 4'd4,
    StWb    = 4'd5,
    StMemRd = 4'd6,
    StPushM = 4'd7,
    StMemWr = 4'd8,
    StJmp   = 4'd9,
    StJz    = 4'd10
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       m_to_s;
    logic       ld_a;
    logic       ld_b;
    logic       src_a;
    logic       src_b;
    logic       push;
    logic       pop;
    logic       tos;
    logic [1:0] alu_op;
    logic       inst_done;
  } ctrl_t;

  // Strobes for a given state; ALU op comes from the opcode low bits only in EXEC.
  function automatic ctrl_t decode(input state_e s, input logic [OPC_W-1:0] opc);
    ctrl_t c;
    c = '0;
    case (s)
      StIf: begin
        c.mem_read = 1'b1;
        c.ir_write = 1'b1;
        c.src_a    = 1'b1;
        c.src_b    = 1'b1;
        c.pc_write = 1'b1;
      end
      StPopA: begin
        c.pop  = 1'b1;
        c.ld_a = 1'b1;
      end
      StPopB: begin
        c.pop  = 1'b1;
        c.ld_b = 1'b1;
      end
      StExec:  c.alu_op = opc[1:0];
      StWb: begin
        c.push      = 1'b1;
        c.inst_done = 1'b1;
      end
      StMemRd: begin
        c.i_or_d   = 1'b1;
        c.mem_read = 1'b1;
      end
      StPushM: begin
        c.m_to_s    = 1'b1;
        c.push      = 1'b1;
        c.inst_done = 1'b1;
      end
      StMemWr: begin
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
        c.inst_done = 1'b1;
      end
      StJmp: begin
        c.pc_src    = 1'b1;
        c.pc_write  = 1'b1;
        c.inst_done = 1'b1;
      end
      StJz: begin
        c.tos           = 1'b1;
        c.pc_src        = 1'b1;
        c.pc_write_cond = 1'b1;
        c.inst_done     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d, ctrl_out;

  always_comb begin
    state_d = StIf;
    case (state_q)
      StIf: state_d = StId;
      StId: begin
        case (opcode)
          3'b100:  state_d = StMemRd;
          3'b110:  state_d = StJmp;
          3'b111:  state_d = StJz;
          default: state_d = StPopA;
        endcase
      end
      StPopA: begin
        case (opcode)
          3'b000, 3'b001, 3'b010: state_d = StPopB;
          3'b011:                 state_d = StExec;
          3'b101:                 state_d = StMemWr;
          default:                state_d = StIf;
        endcase
      end
      StPopB:  state_d = StExec;
      StExec:  state_d = StWb;
      StMemRd: state_d = StPushM;
      default: state_d = StIf;
    endcase
    ctrl_d = decode(state_d, opcode);
  end

  // Reset parks the strobes at the IF pattern so the first cycle after release fetches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIf;
      ctrl_q  <= decode(StIf, '0);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ctrl_out    = rst ? '0 : ctrl_q;
  assign pcWrite     = ctrl_out.pc_write;
  assign pcWriteCond = ctrl_out.pc_write_cond;
  assign pcSrc       = ctrl_out.pc_src;
  assign IorD        = ctrl_out.i_or_d;
  assign memRead     = ctrl_out.mem_read;
  assign memWrite    = ctrl_out.mem_write;
  assign IRWrite     = ctrl_out.ir_write;
  assign MtoS        = ctrl_out.m_to_s;
  assign ldA         = ctrl_out.ld_a;
  assign ldB         = ctrl_out.ld_b;
  assign srcA        = ctrl_out.src_a;
  assign srcB        = ctrl_out.src_b;
  assign push        = ctrl_out.push;
  assign pop         = ctrl_out.pop;
  assign tos         = ctrl_out.tos;
  assign ALUOp       = ctrl_out.alu_op;
  assign instDone    = ctrl_out.inst_done;
  assign state       = state_q;

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: per-opcode state walks and strobe patterns against a
// table-driven reference, random back-to-back instructions, and async reset behaviour.
module tb_stack_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS;
  logic       ldA, ldB, srcA, srcB, push, pop, tos, instDone;
  logic [1:0] ALUOp;
  logic [3:0] state;

  int n_cmp  = 0;
  int n_fail = 0;

  stack_controller #(.STATE_W(4), .OPC_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSrc(pcSrc), .IorD(IorD),
    .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite), .MtoS(MtoS),
    .ldA(ldA), .ldB(ldB), .srcA(srcA), .srcB(srcB), .push(push), .pop(pop),
    .tos(tos), .ALUOp(ALUOp), .state(state), .instDone(instDone)
  );

  always #5 clk = ~clk;

  // Order: pcWrite pcWriteCond pcSrc IorD memRead memWrite IRWrite MtoS ldA ldB
  //        srcA srcB push pop tos ALUOp[1:0] instDone
  function automatic logic [17:0] observed();
    return {pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS, ldA, ldB,
            srcA, srcB, push, pop, tos, ALUOp, instDone};
  endfunction

  // Reference: state walk of each instruction class.
  function automatic int seq_of(input logic [2:0] op, output int s [0:5]);
    for (int i = 0; i < 6; i++) s[i] = 0;
    s[0] = 0;
    s[1] = 1;
    case (op)
      3'd0, 3'd1, 3'd2: begin s[2] = 2; s[3] = 3; s[4] = 4; s[5] = 5; return 6; end
      3'd3:             begin s[2] = 2; s[3] = 4; s[4] = 5; return 5; end
      3'd4:             begin s[2] = 6; s[3] = 7; return 4; end
      3'd5:             begin s[2] = 2; s[3] = 8; return 4; end
      3'd6:             begin s[2] = 9; return 3; end
      default:          begin s[2] = 10; return 3; end
    endcase
  endfunction

  // Reference: strobes asserted in each state.
  function automatic logic [17:0] exp_out(input int st, input logic [2:0] op);
    logic pw, pwc, ps, iod, mr, mw, irw, mts, la, lb, sa, sb, pu, po, to, id;
    logic [1:0] ao;
    {pw, pwc, ps, iod, mr, mw, irw, mts, la, lb, sa, sb, pu, po, to, id} = '0;
    ao = 2'b00;
    case (st)
      0:  begin mr = 1; irw = 1; sa = 1; sb = 1; pw = 1; end
      2:  begin po = 1; la = 1; end
      3:  begin po = 1; lb = 1; end
      4:  ao = op[1:0];
      5:  begin pu = 1; id = 1; end
      6:  begin iod = 1; mr = 1; end
      7:  begin mts = 1; pu = 1; id = 1; end
      8:  begin iod = 1; mw = 1; id = 1; end
      9:  begin ps = 1; pw = 1; id = 1; end
      10: begin to = 1; ps = 1; pwc = 1; id = 1; end
      default: ;
    endcase
    return {pw, pwc, ps, iod, mr, mw, irw, mts, la, lb, sa, sb, pu, po, to, ao, id};
  endfunction

  // Called away from the clock edge with the DUT in IF; runs one whole instruction.
  task automatic run_instr(input logic [2:0] op, input string tag);
    int s [0:5];
    int n;
    n = seq_of(op, s);
    opcode = op;
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (state !== 4'(s[i])) begin
        n_fail++;
        $display("FAIL %s op=%0d step%0d state: got %0d expected %0d", tag, op, i, state, s[i]);
      end
      n_cmp++;
      if (observed() !== exp_out(s[i], op)) begin
        n_fail++;
        $display("FAIL %s op=%0d step%0d outputs: got %b expected %b", tag, op, i,
                 observed(), exp_out(s[i], op));
      end
      n_cmp++;
      if ((push && pop) || (memRead && memWrite)) begin
        n_fail++;
        $display("FAIL %s exclusivity: got push/pop=%b%b rd/wr=%b%b expected not both",
                 tag, push, pop, memRead, memWrite);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    opcode = 3'd0;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (observed() !== 18'd0 || state !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_hold: got out=%b state=%0d expected 0/0", observed(), state);
      end
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (state !== 4'd0 || observed() !== exp_out(0, 3'd0)) begin
      n_fail++;
      $display("FAIL reset_release: got state=%0d out=%b expected 0/%b", state, observed(),
               exp_out(0, 3'd0));
    end
  endtask

  task automatic test_sub();      run_instr(3'd1, "sub");  endtask
  task automatic test_not();      run_instr(3'd3, "not");  endtask

  task automatic test_push_pop();
    run_instr(3'd4, "push");
    run_instr(3'd5, "pop");
  endtask

  task automatic test_jumps();
    run_instr(3'd7, "jz");
    run_instr(3'd6, "jmp");
    run_instr(3'd0, "add");
    run_instr(3'd2, "and");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 24; k++) run_instr(3'($urandom_range(0, 7)), "rand");
  endtask

  task automatic test_reset_mid_popb();
    int waited;
    opcode = 3'd0;
    waited = 0;
    while (state !== 4'd3 && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (state !== 4'd3) begin
      n_fail++;
      $display("FAIL reach_popb: got state=%0d expected 3", state);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (state !== 4'd0 || observed() !== 18'd0) begin
      n_fail++;
      $display("FAIL async_reset: got state=%0d out=%b expected 0/0", state, observed());
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (push !== 1'b0 || pop !== 1'b0 || memWrite !== 1'b0 || state !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_no_push: got push=%b pop=%b wr=%b state=%0d expected 0",
                 push, pop, memWrite, state);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    run_instr(3'd1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_sub();
    test_not();
    test_push_pop();
    test_jumps();
    test_back_to_back();
    test_reset_mid_popb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_controller.md
Name: stack_controller

Overview:
- Multicycle control unit for the 8-bit stack-machine datapath; sits directly upstream of it.
- Consumes the 3-bit `opcode` (IR[7:5]) from the datapath and produces every datapath control strobe each cycle.
- Moore FSM: outputs depend on current state only, except `ALUOp`, which also depends on `opcode` in the EXEC state.
- Also exports the current state and an instruction-retire pulse for debug and verification.

Parameters:
- STATE_W, 4, state register width (11 states used).
- OPC_W, 3, opcode width; fixed; must not be changed.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  3  instruction class from the datapath IR[7:5].
- pcWrite  output  1  unconditional PC load.
- pcWriteCond  output  1  PC load qualified by the datapath zero flag.
- pcSrc  output  1  0 = PC+1 from ALU, 1 = IR[4:0].
- IorD  output  1  memory address select: 0 = PC, 1 = IR[4:0].
- memRead  output  1  memory read enable.
- memWrite  output  1  memory write enable; write data is register A.
- IRWrite  output  1  IR load.
- MtoS  output  1  stack input select: 0 = ALU register, 1 = MDR.
- ldA  output  1  load A from stack output.
- ldB  output  1  load B from stack output.
- srcA  output  1  ALU A select: 0 = A, 1 = zero-extended PC.
- srcB  output  1  ALU B select: 0 = B, 1 = constant 1.
- push  output  1  stack push.
- pop  output  1  stack pop.
- tos  output  1  stack top read without pop.
- ALUOp  output  2  00 add, 01 sub, 10 and, 11 not (A).
- state  output  4  current FSM state.
- instDone  output  1  high in the final state of every instruction.

Behaviour:
- Opcode map: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH addr, 101 POP addr, 110 JMP addr, 111 JZ addr. Every code is legal.
- State encoding: IF=0, ID=1, POPA=2, POPB=3, EXEC=4, WB=5, MEMRD=6, PUSHM=7, MEMWR=8, JMP=9, JZ=10. Codes 11-15 are unused; if entered, next state is IF and all outputs are 0.
- Output default in every state is 0. Only the signals listed per state are asserted.
- IF: memRead, IORD=0, IRWrite, srcA, srcB, ALUOp=00, pcSrc=0, pcWrite. This fetches the instruction and sets PC <= PC+1. Next: ID.
- ID: no outputs asserted. Dispatch on opcode: 000-011 -> POPA; 100 -> MEMRD; 101 -> POPA; 110 -> JMP; 111 -> JZ.
- POPA: pop, ldA. Next: POPB for 000-010; EXEC for 011; MEMWR for 101.
- POPB: pop, ldB. Next: EXEC.
- EXEC: srcA=0, srcB=0, ALUOp = opcode[1:0]. The ALU register latches at the end of this cycle. Next: WB.
- WB: MtoS=0, push, instDone. Next: IF.
- MEMRD: IorD, memRead. The MDR latches at the end of this cycle. Next: PUSHM.
- PUSHM: MtoS, push, instDone. Next: IF.
- MEMWR: IorD, memWrite, instDone. Next: IF.
- JMP: pcSrc, pcWrite, instDone. Next: IF.
- JZ: tos, pcSrc, pcWriteCond, instDone. Next: IF. PC loads only if the stack top is 0; the stack is not popped.
- Cycles per instruction: ADD/SUB/AND 6; NOT 5; PUSH 4; POP 4; JMP 3; JZ 3.
- `opcode` is sampled in ID, POPA and EXEC. IR only changes in IF, so `opcode` is stable for the whole instruction.
- Reset, asynchronous: state <= IF immediately.
  - While rst=1, every control output and instDone are forced to 0; `state` reads 0.
  - The first rising edge after deassertion is the first cycle in which IF outputs are asserted.
  - Reset mid-instruction aborts the instruction; no push, pop or write occurs after rst rises.
- At most one of push/pop is ever high. memRead and memWrite are never high together.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 while rst=1; first post-reset cycle state=0 with memRead=IRWrite=pcWrite=1.
- opcode=001 (SUB) -> state sequence 0,1,2,3,4,5,0; in EXEC ALUOp=01; push and instDone high only in state 5.
- opcode=011 (NOT) -> sequence 0,1,2,4,5; POPB is skipped; ALUOp=11 in EXEC.
- opcode=100 then opcode=101 -> PUSH: 0,1,6,7 with IorD=memRead=1 in 6 and MtoS=push=1 in 7. POP: 0,1,2,8 with memWrite=IorD=1 in 8.
- opcode=111 -> sequence 0,1,10 with tos=pcWriteCond=pcSrc=1 and pcWrite=0. opcode=110 -> sequence 0,1,9 with pcWrite=pcSrc=1.
- Assert rst asynchronously mid-POPB (state=3) -> state and all outputs go to 0 before the next clock edge; no push follows.
